// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding I-cache requests, 2-entry
// instruction FIFO and redirect/drain handling. Optional macro: FETCH_JAL_PREDICT_EN.
module instr_fetch_unit #(
    parameter int unsigned     BITS     = 32,
    parameter logic [BITS-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ic_req,
    output logic [BITS-1:0] ic_addr,
    input  logic            ic_ready,
    input  logic [BITS-1:0] ic_rdata,
    input  logic            redirect_valid,
    input  logic [BITS-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [BITS-1:0] instr,
    output logic [BITS-1:0] instr_pc,
    output logic [6:0]      Opcode,
    output logic [2:0]      Funct3,
    output logic [6:0]      Funct7,
    output logic            instr_pred_taken
);

    typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] pc_q, pc_d;
    logic [BITS-1:0] drain_addr_q, drain_addr_d;

    logic [BITS-1:0] fifo_instr_q [2];
    logic [BITS-1:0] fifo_pc_q    [2];
    logic            fifo_pred_q  [2];
    logic            rd_ptr_q, wr_ptr_q;
    logic [1:0]      count_q, count_d;

    logic            complete, push, pop;
    logic [1:0]      count_after;
    logic [BITS-1:0] next_pc;
    logic            pred_taken;

    assign ic_req   = (state_q == FETCH) || (state_q == DRAIN);
    assign complete = ic_req && ic_ready;
    assign pop      = instr_valid && instr_ready;
    assign push     = (state_q == FETCH) && complete && !redirect_valid;

    always_comb begin
        ic_addr = '0;
        if (state_q == FETCH)
            ic_addr = pc_q;
        else if (state_q == DRAIN)
            ic_addr = drain_addr_q;
    end

`ifdef FETCH_JAL_PREDICT_EN
    logic            is_jal;
    logic [BITS-1:0] jal_imm;
    assign is_jal  = (ic_rdata[6:0] == 7'b110_1111);
    assign jal_imm = {{(BITS-20){ic_rdata[31]}}, ic_rdata[19:12], ic_rdata[20],
                      ic_rdata[30:21], 1'b0};
    assign pred_taken = is_jal;
    assign next_pc    = is_jal ? (pc_q + jal_imm) : (pc_q + BITS'(4));
`else
    assign pred_taken = 1'b0;
    assign next_pc    = pc_q + BITS'(4);
`endif

    assign count_after = count_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        count_d      = count_after;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (complete) begin
                    pc_d = next_pc;
                    if (count_after > 2'd1)
                        state_d = FULL;
                end
            end
            FULL:  if (count_after == 2'd1) state_d = FETCH;
            DRAIN: if (complete) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        // Redirect overrides everything; an unfinished request must still be
        // drained at its original address before the new target is issued.
        if (redirect_valid) begin
            pc_d    = {redirect_pc[BITS-1:2], 2'b00};
            count_d = '0;
            if (ic_req && !ic_ready) begin
                state_d = DRAIN;
                if (state_q != DRAIN)
                    drain_addr_d = pc_q;
            end else begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            pc_q            <= RESET_PC;
            drain_addr_q    <= '0;
            count_q         <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            fifo_instr_q[0] <= '0;
            fifo_instr_q[1] <= '0;
            fifo_pc_q[0]    <= '0;
            fifo_pc_q[1]    <= '0;
            fifo_pred_q[0]  <= 1'b0;
            fifo_pred_q[1]  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            count_q      <= count_d;
            if (push) begin
                fifo_instr_q[wr_ptr_q] <= ic_rdata;
                fifo_pc_q[wr_ptr_q]    <= pc_q;
                fifo_pred_q[wr_ptr_q]  <= pred_taken;
            end
            if (redirect_valid) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                rd_ptr_q <= rd_ptr_q ^ pop;
                wr_ptr_q <= wr_ptr_q ^ push;
            end
        end
    end

    assign instr_valid      = (count_q != 2'd0);
    assign instr            = instr_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign instr_pc         = instr_valid ? fifo_pc_q[rd_ptr_q]    : '0;
    assign instr_pred_taken = instr_valid && fifo_pred_q[rd_ptr_q];
    assign Opcode           = instr[6:0];
    assign Funct3           = instr[14:12];
    assign Funct7           = instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, streaming, backpressure,
// redirects, PC wrap and JAL prediction (follows FETCH_JAL_PREDICT_EN).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req, ic_ready;
    logic [31:0] ic_addr, ic_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic [6:0]  Opcode, Funct7;
    logic [2:0]  Funct3;
    logic        instr_pred_taken;

    // Second instance for the wrap-around RESET_PC; shares all inputs.
    logic        w_ic_req, w_instr_valid, w_pred;
    logic [31:0] w_ic_addr, w_instr, w_instr_pc;
    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3;

    int unsigned vec  = 0;
    int unsigned miss = 0;

    // Cache model: ready after 'waits' stall cycles unless held off.
    int unsigned waits;
    int unsigned wait_cnt;
    logic        hold;
    logic        jal_en;

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= 0;
        else if (ic_req && !ic_ready)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    assign ic_ready = !hold && (wait_cnt >= waits);
    assign ic_rdata = (jal_en && ic_addr == 32'h40) ? 32'h0100_006F : {ic_addr[23:0], 8'h13};

    instr_fetch_unit #(.BITS(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7),
        .instr_pred_taken(instr_pred_taken)
    );

    instr_fetch_unit #(.BITS(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .ic_req(w_ic_req), .ic_addr(w_ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(w_instr_valid), .instr_ready(instr_ready),
        .instr(w_instr), .instr_pc(w_instr_pc),
        .Opcode(w_opcode), .Funct3(w_funct3), .Funct7(w_funct7),
        .instr_pred_taken(w_pred)
    );

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves rst released #1 after an edge, so the next edge is "edge 1".
    task automatic do_reset(input int unsigned w);
        rst = 1'b1; waits = w; hold = 1'b0; jal_en = 1'b0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; waits = 0; hold = 1'b0; jal_en = 1'b0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick(2);
        vec++; if ({ic_req, ic_addr} !== 33'h0) begin miss++;
            $display("FAIL reset_ic: req=%b addr=%h want 0/0", ic_req, ic_addr); end
        vec++; if ({instr_valid, instr, instr_pc, instr_pred_taken} !== 66'h0) begin miss++;
            $display("FAIL reset_head: v=%b instr=%h pc=%h pt=%b want all 0",
                     instr_valid, instr, instr_pc, instr_pred_taken); end
        vec++; if ({Opcode, Funct3, Funct7} !== 17'h0) begin miss++;
            $display("FAIL reset_fields: %h %h %h want 0", Opcode, Funct3, Funct7); end
        vec++; if ({w_ic_req, w_ic_addr, w_instr_valid} !== 34'h0) begin miss++;
            $display("FAIL reset_wrap_dut: req=%b addr=%h v=%b want 0", w_ic_req, w_ic_addr, w_instr_valid); end
        rst = 1'b0;
        instr_ready = 1'b1;
        tick(1);
        vec++; if (ic_req !== 1'b1 || ic_addr !== 32'h0 || instr_valid !== 1'b0) begin miss++;
            $display("FAIL first_req: req=%b addr=%h v=%b want 1/0/0", ic_req, ic_addr, instr_valid); end
    endtask

    task automatic test_stream;
        // Continues from test_reset: zero-wait cache, decode always ready.
        tick(1);
        vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h0000_0013) begin miss++;
            $display("FAIL stream0: v=%b pc=%h instr=%h want 1/0/00000013", instr_valid, instr_pc, instr); end
        vec++; if (ic_addr !== 32'h4) begin miss++;
            $display("FAIL stream0_addr: got %h want 00000004", ic_addr); end
        tick(1);
        vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== 32'h0000_0413) begin miss++;
            $display("FAIL stream4: v=%b pc=%h instr=%h want 1/4/00000413", instr_valid, instr_pc, instr); end
        tick(1);
        vec++; if (instr_pc !== 32'h8 || Opcode !== 7'h13 || instr_pred_taken !== 1'b0) begin miss++;
            $display("FAIL stream8: pc=%h op=%h pt=%b want 8/13/0", instr_pc, Opcode, instr_pred_taken); end
    endtask

    task automatic test_backpressure;
        do_reset(3);
        tick(4);
        vec++; if (instr_valid !== 1'b0 || ic_req !== 1'b1 || ic_addr !== 32'h0) begin miss++;
            $display("FAIL bp_wait: v=%b req=%b addr=%h want 0/1/0", instr_valid, ic_req, ic_addr); end
        tick(1);
        vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || ic_addr !== 32'h4) begin miss++;
            $display("FAIL bp_first: v=%b pc=%h addr=%h want 1/0/4", instr_valid, instr_pc, ic_addr); end
        tick(4);
        vec++; if (ic_req !== 1'b0 || instr_pc !== 32'h0 || instr_valid !== 1'b1) begin miss++;
            $display("FAIL bp_full: req=%b pc=%h v=%b want 0/0/1", ic_req, instr_pc, instr_valid); end
        tick(3);
        vec++; if (ic_req !== 1'b0) begin miss++;
            $display("FAIL bp_no_third: req=%b want 0", ic_req); end
        instr_ready = 1'b1;
        tick(1);
        instr_ready = 1'b0;
        vec++; if (instr_pc !== 32'h4 || ic_req !== 1'b1 || ic_addr !== 32'h8) begin miss++;
            $display("FAIL bp_resume: pc=%h req=%b addr=%h want 4/1/8", instr_pc, ic_req, ic_addr); end
    endtask

    task automatic test_redirect_wait;
        do_reset(0);
        instr_ready = 1'b1;
        tick(3);
        vec++; if (ic_addr !== 32'h8 || instr_pc !== 32'h4) begin miss++;
            $display("FAIL rw_setup: addr=%h pc=%h want 8/4", ic_addr, instr_pc); end
        hold = 1'b1; instr_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick(1);
        redirect_valid = 1'b0;
        vec++; if (ic_req !== 1'b1 || ic_addr !== 32'h8 || instr_valid !== 1'b0) begin miss++;
            $display("FAIL rw_drain: req=%b addr=%h v=%b want 1/8/0", ic_req, ic_addr, instr_valid); end
        tick(2);
        vec++; if (ic_addr !== 32'h8 || instr_valid !== 1'b0) begin miss++;
            $display("FAIL rw_hold: addr=%h v=%b want 8/0", ic_addr, instr_valid); end
        hold = 1'b0;
        tick(1);
        vec++; if (ic_addr !== 32'h100 || ic_req !== 1'b1 || instr_valid !== 1'b0) begin miss++;
            $display("FAIL rw_target: addr=%h req=%b v=%b want 100/1/0", ic_addr, ic_req, instr_valid); end
        instr_ready = 1'b1;
        tick(1);
        vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h0001_0013) begin miss++;
            $display("FAIL rw_first: v=%b pc=%h instr=%h want 1/100/00010013", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_redirect_same_edge;
        do_reset(0);
        instr_ready = 1'b1;
        tick(2);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick(1);
        redirect_valid = 1'b0;
        vec++; if (instr_valid !== 1'b0 || ic_addr !== 32'h200 || ic_req !== 1'b1) begin miss++;
            $display("FAIL rs_flush: v=%b addr=%h req=%b want 0/200/1", instr_valid, ic_addr, ic_req); end
        tick(1);
        vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin miss++;
            $display("FAIL rs_first: v=%b pc=%h want 1/200", instr_valid, instr_pc); end
    endtask

    task automatic test_wrap;
        do_reset(0);
        instr_ready = 1'b1;
        tick(1);
        vec++; if (w_ic_addr !== 32'hFFFF_FFFC) begin miss++;
            $display("FAIL wrap_req: addr=%h want fffffffc", w_ic_addr); end
        tick(1);
        vec++; if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC || w_ic_addr !== 32'h0) begin miss++;
            $display("FAIL wrap_first: v=%b pc=%h addr=%h want 1/fffffffc/0", w_instr_valid, w_instr_pc, w_ic_addr); end
        tick(1);
        vec++; if (w_instr_pc !== 32'h0) begin miss++;
            $display("FAIL wrap_second: pc=%h want 0", w_instr_pc); end
    endtask

    task automatic test_jal;
        logic [31:0] exp_addr;
        logic        exp_pt;
`ifdef FETCH_JAL_PREDICT_EN
        exp_addr = 32'h50; exp_pt = 1'b1;
`else
        exp_addr = 32'h44; exp_pt = 1'b0;
`endif
        do_reset(0);
        jal_en = 1'b1;
        tick(1);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick(1);
        redirect_valid = 1'b0;
        vec++; if (ic_addr !== 32'h40 || instr_valid !== 1'b0) begin miss++;
            $display("FAIL jal_req: addr=%h v=%b want 40/0", ic_addr, instr_valid); end
        tick(1);
        vec++; if (instr_pc !== 32'h40 || instr !== 32'h0100_006F || Opcode !== 7'h6F) begin miss++;
            $display("FAIL jal_head: pc=%h instr=%h op=%h want 40/0100006f/6f", instr_pc, instr, Opcode); end
        vec++; if (ic_addr !== exp_addr) begin miss++;
            $display("FAIL jal_next_addr: got %h want %h", ic_addr, exp_addr); end
        vec++; if (instr_pred_taken !== exp_pt) begin miss++;
            $display("FAIL jal_pred: got %b want %b", instr_pred_taken, exp_pt); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect_wait;
        test_redirect_same_edge;
        test_wrap;
        test_jal;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
